pipe_ctrl: RTL and testbench

Parametrised pipeline controller for the five-stage core. It generalises stall generation to N stages and M stall-request sources, and adds three things the core does not yet have: bubble insertion, a counted multi-cycle hold for long-latency EX operations (div/mul), and a flush/redirect state machine for exceptions. It sits beside the stage modules and drives their stall and flush inputs.

---
 rtl/pipe_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges stall requests into a stall depth,
// inserts a bubble behind the deepest held stage, holds EX for counted
// multi-cycle operations and sequences exception redirects.
//
// state | meaning
// RUN   | normal flow; stall depth comes from stallreq and mc_start
// MULTI | long-latency EX op in progress; EX and older stages held
// FLUSH | one cycle after a redirect; stale fetch is dropped
module pipe_ctrl #(
  parameter int                    STAGES    = 6,
  parameter int                    NREQ      = 3,
  parameter int                    SW        = 3,
  parameter logic [NREQ*SW-1:0]    REQ_STAGE = {3'd3, 3'd2, 3'd2},
  parameter int                    MC_STAGE  = 3,
  parameter int                    MCW       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stallreq,
  input  logic              mc_start,
  input  logic [MCW-1:0]    mc_len,
  output logic              mc_done,
  input  logic              exc_req,
  input  logic [31:0]       exc_pc,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic              new_pc_valid,
  output logic [31:0]       new_pc,
  output logic              busy,
  output logic [31:0]       stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MULTI = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [SW-1:0] MC_S = SW'(MC_STAGE);

  state_t         state;
  state_t         state_nxt;
  logic [MCW-1:0] cnt;
  logic [MCW-1:0] cnt_nxt;
  logic [MCW-1:0] eff_len;
  logic           mc_done_nxt;
  logic           ready;
  logic           act;
  logic           has_s;
  logic [SW-1:0]  s_val;

  // Outputs stay quiet during reset and for the first cycle after release.
  assign act = rst & ready;

  // A zero length behaves like a single-cycle operation.
  assign eff_len = (mc_len == '0) ? MCW'(1) : mc_len;

  // Next-state, hold counter and combinational stall/flush/redirect outputs.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    mc_done_nxt  = 1'b0;
    stall        = '0;
    flush        = '0;
    new_pc_valid = 1'b0;
    new_pc       = '0;
    has_s        = 1'b0;
    s_val        = '0;

    if (!act) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (exc_req) begin
      // Redirect wins over everything; an in-flight hold is abandoned.
      flush        = '1;
      new_pc_valid = 1'b1;
      new_pc       = exc_pc;
      state_nxt    = FLUSH;
      cnt_nxt      = '0;
    end else begin
      case (state)
        RUN, MULTI: begin
          for (int i = 0; i < NREQ; i++) begin
            if (stallreq[i]) begin
              if (!has_s || (REQ_STAGE[i*SW +: SW] > s_val)) begin
                s_val = REQ_STAGE[i*SW +: SW];
              end
              has_s = 1'b1;
            end
          end

          if ((state == MULTI) || mc_start) begin
            if (!has_s || (MC_S > s_val)) begin
              s_val = MC_S;
            end
            has_s = 1'b1;
          end

          if (state == RUN) begin
            if (mc_start) begin
              if (eff_len == MCW'(1)) begin
                mc_done_nxt = 1'b1;
              end else begin
                cnt_nxt   = eff_len - MCW'(1);
                state_nxt = MULTI;
              end
            end
          end else begin
            cnt_nxt = cnt - MCW'(1);
            if (cnt <= MCW'(1)) begin
              state_nxt   = RUN;
              mc_done_nxt = 1'b1;
              cnt_nxt     = '0;
            end
          end

          for (int k = 0; k < STAGES; k++) begin
            stall[k] = has_s && (k <= int'(s_val));
            flush[k] = has_s && (k == int'(s_val) + 1);
          end
        end

        FLUSH: begin
          flush[1]  = 1'b1;
          state_nxt = RUN;
        end

        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, hold counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      cnt       <= '0;
      mc_done   <= 1'b0;
      busy      <= 1'b0;
      stall_cnt <= '0;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mc_done   <= mc_done_nxt;
      busy      <= (state_nxt == MULTI);
      stall_cnt <= stall_cnt + {31'd0, stall[0]};
      ready     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed vector table, hand sequences and random
// stimulus, all compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  stallreq;
  logic        mc_start;
  logic [5:0]  mc_len;
  logic        mc_done;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic [5:0]  stall;
  logic [5:0]  flush;
  logic        new_pc_valid;
  logic [31:0] new_pc;
  logic        busy;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .mc_start(mc_start),
    .mc_len(mc_len), .mc_done(mc_done), .exc_req(exc_req), .exc_pc(exc_pc),
    .stall(stall), .flush(flush), .new_pc_valid(new_pc_valid),
    .new_pc(new_pc), .busy(busy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [2:0]  req;
    logic        ms;
    logic [5:0]  len;
    logic        exc;
    logic [31:0] pc;
    logic [5:0]  e_stall;
    logic [5:0]  e_flush;
    logic        e_nv;
    logic [31:0] e_pc;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  vec_t tq[$];

  // behavioural model: remaining hold cycles counted including the current one
  int          rs[3] = '{2, 2, 3};
  bit          m_rdy  = 0;
  bit          m_fl   = 0;
  int          m_rem  = 0;
  bit          m_done = 0;
  bit          m_busy = 0;
  logic [31:0] m_scnt = 0;

  function automatic vec_t mk(input logic r, input logic [2:0] req, input logic ms,
                              input logic [5:0] len, input logic exc, input logic [31:0] pc,
                              input logic [5:0] es, input logic [5:0] ef, input logic env,
                              input logic [31:0] epc, input logic ed, input logic eb);
    vec_t v;
    v.r = r; v.req = req; v.ms = ms; v.len = len; v.exc = exc; v.pc = pc;
    v.e_stall = es; v.e_flush = ef; v.e_nv = env; v.e_pc = epc; v.e_done = ed; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input bit tab);
    logic [5:0]  es, ef;
    logic        env;
    logic [31:0] epc;
    int          depth;
    @(negedge clk);
    rst = v.r; stallreq = v.req; mc_start = v.ms; mc_len = v.len;
    exc_req = v.exc; exc_pc = v.pc;
    #1;
    es = 0; ef = 0; env = 0; epc = 0;
    if (!v.r || !m_rdy) begin
    end else if (v.exc) begin
      ef = 6'b111111; env = 1; epc = v.pc;
    end else if (m_fl) begin
      ef = 6'b000010;
    end else begin
      depth = -1;
      for (int i = 0; i < 3; i++) if (v.req[i] && rs[i] > depth) depth = rs[i];
      if ((m_rem > 0 || v.ms) && depth < 3) depth = 3;
      if (depth >= 0) begin
        es = 6'((1 << (depth + 1)) - 1);
        if (depth + 1 < 6) ef = 6'(1 << (depth + 1));
      end
    end
    chk("stall", 32'(stall), 32'(es));
    chk("flush", 32'(flush), 32'(ef));
    chk("new_pc_valid", 32'(new_pc_valid), 32'(env));
    chk("new_pc", new_pc, epc);
    chk("mc_done", 32'(mc_done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("stall_cnt", stall_cnt, m_scnt);
    if (tab) begin
      chk("tab_stall", 32'(stall), 32'(v.e_stall));
      chk("tab_flush", 32'(flush), 32'(v.e_flush));
      chk("tab_nv", 32'(new_pc_valid), 32'(v.e_nv));
      chk("tab_pc", new_pc, v.e_pc);
      chk("tab_done", 32'(mc_done), 32'(v.e_done));
      chk("tab_busy", 32'(busy), 32'(v.e_busy));
    end
    // advance the model to the state after the coming rising edge
    if (!v.r) begin
      m_rdy = 0; m_fl = 0; m_rem = 0; m_done = 0; m_busy = 0; m_scnt = 0;
    end else if (!m_rdy) begin
      m_rdy = 1; m_fl = 0; m_rem = 0; m_done = 0; m_busy = 0;
    end else if (v.exc) begin
      m_fl = 1; m_rem = 0; m_done = 0; m_busy = 0;
    end else if (m_fl) begin
      m_fl = 0; m_done = 0; m_busy = 0;
    end else begin
      if (m_rem == 0 && v.ms) m_rem = (v.len == 0) ? 1 : int'(v.len);
      if (m_rem > 0) begin
        m_rem--;
        m_done = (m_rem == 0);
      end else begin
        m_done = 0;
      end
      m_busy = (m_rem > 0);
      m_scnt = m_scnt + 32'(es[0]);
    end
  endtask

  initial begin
    vec_t v;
    int   cnt63;
    int   dones;
    rst = 0; stallreq = 0; mc_start = 0; mc_len = 0; exc_req = 0; exc_pc = 0;

    // r req ms len exc pc | stall flush nv pc done busy
    tq.push_back(mk(0,3'b000,0,0,0,0,           6'b000000,6'b000000,0,0,0,0));
    tq.push_back(mk(0,3'b000,0,0,0,0,           6'b000000,6'b000000,0,0,0,0));
    tq.push_back(mk(1,3'b001,0,0,0,0,           6'b000000,6'b000000,0,0,0,0));
    tq.push_back(mk(1,3'b001,0,0,0,0,           6'b000111,6'b001000,0,0,0,0));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b000000,6'b000000,0,0,0,0));
    tq.push_back(mk(1,3'b000,1,4,0,0,           6'b001111,6'b010000,0,0,0,0));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b001111,6'b010000,0,0,0,1));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b001111,6'b010000,0,0,0,1));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b001111,6'b010000,0,0,0,1));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b000000,6'b000000,0,0,1,0));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b000000,6'b000000,0,0,0,0));
    tq.push_back(mk(1,3'b000,1,0,0,0,           6'b001111,6'b010000,0,0,0,0));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b000000,6'b000000,0,0,1,0));
    tq.push_back(mk(1,3'b000,1,1,0,0,           6'b001111,6'b010000,0,0,0,0));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b000000,6'b000000,0,0,1,0));
    tq.push_back(mk(1,3'b000,1,8,0,0,           6'b001111,6'b010000,0,0,0,0));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b001111,6'b010000,0,0,0,1));
    tq.push_back(mk(1,3'b000,0,0,1,32'hBFC00380,6'b000000,6'b111111,1,32'hBFC00380,0,1));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b000000,6'b000010,0,0,0,0));
    for (int i = 0; i < 8; i++)
      tq.push_back(mk(1,3'b000,0,0,0,0,         6'b000000,6'b000000,0,0,0,0));
    tq.push_back(mk(1,3'b000,1,3,0,0,           6'b001111,6'b010000,0,0,0,0));
    tq.push_back(mk(1,3'b101,0,0,0,0,           6'b001111,6'b010000,0,0,0,1));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b001111,6'b010000,0,0,0,1));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b000000,6'b000000,0,0,1,0));
    tq.push_back(mk(1,3'b000,1,8,0,0,           6'b001111,6'b010000,0,0,0,0));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b001111,6'b010000,0,0,0,1));
    tq.push_back(mk(0,3'b011,0,0,1,32'h55,      6'b000000,6'b000000,0,0,0,1));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b000000,6'b000000,0,0,0,0));
    for (int i = 0; i < 8; i++)
      tq.push_back(mk(1,3'b000,0,0,0,0,         6'b000000,6'b000000,0,0,0,0));
    tq.push_back(mk(1,3'b000,1,5,1,32'h1234,    6'b000000,6'b111111,1,32'h1234,0,0));
    tq.push_back(mk(1,3'b011,1,5,0,0,           6'b000000,6'b000010,0,0,0,0));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b000000,6'b000000,0,0,0,0));
    tq.push_back(mk(1,3'b000,0,0,1,32'hA0,      6'b000000,6'b111111,1,32'hA0,0,0));
    tq.push_back(mk(1,3'b000,0,0,1,32'hB0,      6'b000000,6'b111111,1,32'hB0,0,0));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b000000,6'b000010,0,0,0,0));
    tq.push_back(mk(1,3'b000,1,2,0,0,           6'b001111,6'b010000,0,0,0,0));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b001111,6'b010000,0,0,0,1));
    tq.push_back(mk(1,3'b000,0,0,1,32'hC0,      6'b000000,6'b111111,1,32'hC0,1,0));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b000000,6'b000010,0,0,0,0));
    tq.push_back(mk(1,3'b010,0,0,0,0,           6'b000111,6'b001000,0,0,0,0));
    tq.push_back(mk(1,3'b100,0,0,0,0,           6'b001111,6'b010000,0,0,0,0));
    tq.push_back(mk(1,3'b000,0,0,0,0,           6'b000000,6'b000000,0,0,0,0));

    foreach (tq[i]) apply(tq[i], 1'b1);

    // longest legal hold: 63 stall cycles, then a single done pulse
    apply(mk(1,3'b000,1,63,0,0,0,0,0,0,0,0), 1'b0);
    cnt63 = (stall[0] === 1'b1) ? 1 : 0;
    dones = 0;
    for (int c = 0; c < 80; c++) begin
      apply(mk(1,3'b000,0,0,0,0,0,0,0,0,0,0), 1'b0);
      if (stall[0] === 1'b1) cnt63++;
      if (mc_done === 1'b1) dones++;
    end
    chk("len63_stall_cycles", 32'(cnt63), 32'd63);
    chk("len63_done_pulses", 32'(dones), 32'd1);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      v = mk(1,0,0,0,0,0,0,0,0,0,0,0);
      v.r   = ($urandom_range(0, 99) != 0);
      v.req = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      v.ms  = ($urandom_range(0, 7) == 0);
      v.len = ($urandom_range(0, 15) == 0) ? 6'($urandom) : 6'($urandom_range(0, 6));
      v.exc = ($urandom_range(0, 24) == 0);
      v.pc  = $urandom;
      apply(v, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
